// File: rtl/booth_mul_sched.sv
// Two-requester round-robin scheduler around one sequential radix-2 Booth multiplier.
// One recode/add/shift step per clock; the product is returned on the owner's result port.
module booth_mul_sched #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [W-1:0]     x0,
  input  logic [W-1:0]     y0,
  input  logic             req1,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     y1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [2*W-1:0]   z0,
  output logic [2*W-1:0]   z1,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(W + 1);

  state_t          state_reg, state_next;
  logic [W:0]      a_reg;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    m_reg;
  logic            e_reg;
  logic [CW-1:0]   cnt_reg;
  logic            owner_reg;
  logic            last_reg;

  logic            grant;
  logic            grant_port;
  logic            last_step;
  logic [W:0]      m_ext;
  logic [W:0]      a_sum;
  logic [W:0]      a_shift;
  logic [W-1:0]    q_shift;
  logic [2*W-1:0]  product;

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_port = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          grant = 1'b1;
          // On contention the port not served last wins.
          grant_port = (req0 && req1) ? ~last_reg : req1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == CW'(W - 1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A is one bit wider than M so that subtracting M = -2^(W-1) cannot overflow.
  always_comb begin
    m_ext = {m_reg[W-1], m_reg};
    case ({q_reg[0], e_reg})
      2'b01:   a_sum = a_reg + m_ext;
      2'b10:   a_sum = a_reg - m_ext;
      default: a_sum = a_reg;
    endcase
    a_shift = {a_sum[W], a_sum[W:1]};
    q_shift = {a_sum[0], q_reg[W-1:1]};
    product = {a_shift[W-1:0], q_shift};
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      e_reg     <= 1'b0;
      cnt_reg   <= '0;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      z0        <= '0;
      z1        <= '0;
    end else begin
      state_reg <= state_next;
      ack0      <= grant && !grant_port;
      ack1      <= grant && grant_port;
      done0     <= last_step && !owner_reg;
      done1     <= last_step && owner_reg;
      if (grant) begin
        q_reg     <= grant_port ? x1 : x0;
        m_reg     <= grant_port ? y1 : y0;
        a_reg     <= '0;
        e_reg     <= 1'b0;
        cnt_reg   <= '0;
        owner_reg <= grant_port;
        last_reg  <= grant_port;
      end else if (state_reg == RUN) begin
        a_reg   <= a_shift;
        q_reg   <= q_shift;
        e_reg   <= q_reg[0];
        cnt_reg <= cnt_reg + 1'b1;
        if (last_step) begin
          if (owner_reg) z1 <= product;
          else           z0 <= product;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched (W=4): the driver queues expected products,
// a negedge monitor pops and checks them whenever a done pulse appears.
module tb_booth_mul_sched;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [W-1:0]   x0, y0, x1, y1;
  logic           ack0, ack1, done0, done1, busy;
  logic [2*W-1:0] z0, z1;

  int compared   = 0;
  int mismatched = 0;

  logic [2*W:0]   exp_q[$];
  logic [2*W-1:0] hold0 = '0;
  logic [2*W-1:0] hold1 = '0;

  booth_mul_sched #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .y0(y0),
    .req1(req1), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .z0(z0), .z1(z1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also checks pulse exclusivity
  // and that the non-owner result holds.
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (rst) begin
      hold0 = '0;
      hold1 = '0;
    end else begin
      if (int'(ack0) + int'(ack1) + int'(done0) + int'(done1) > 1)
        check("pulse_exclusive", {ack0, ack1, done0, done1}, 0);
      if (done0 || done1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {done1, done0}, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_port", int'(done1), int'(e[2*W]));
          if (e[2*W]) begin
            check("z1", z1, e[2*W-1:0]);
            check("z0_hold", z0, hold0);
            hold1 = e[2*W-1:0];
          end else begin
            check("z0", z0, e[2*W-1:0]);
            check("z1_hold", z1, hold1);
            hold0 = e[2*W-1:0];
          end
          $display("done port=%0d z0=%h z1=%h", int'(done1), z0, z1);
        end
      end
    end
  end

  task automatic drive(input bit port, input bit r, input logic [W-1:0] x, input logic [W-1:0] y);
    if (port) begin req1 = r; x1 = x; y1 = y; end
    else      begin req0 = r; x0 = x; y0 = y; end
  endtask

  // Called at a negedge with the block idle; returns at a negedge with the block idle again.
  task automatic op(input bit port, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [2*W-1:0] expz, input bit disturb);
    int n;
    int m;
    exp_q.push_back({port, expz});
    drive(port, 1'b1, x, y);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? ack1 : ack0) && n < 20);
    check("ack_latency", n, 1);
    m = 0;
    if (disturb) begin
      drive(port, 1'b1, ~x, ~y);
      @(negedge clk);
      m++;
    end
    drive(port, 1'b0, disturb ? ~x : x, disturb ? ~y : y);
    while (!(port ? done1 : done0) && m < 20) begin
      @(negedge clk);
      m++;
    end
    check("done_latency", m, W);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int cyc;
    int ack_cyc[4];
    int ack_port[4];
    logic signed [W-1:0] sx, sy;
    logic signed [2*W-1:0] sp;

    req0 = 0; req1 = 0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    do_reset();
    check("reset_z0", z0, 0);
    check("reset_z1", z1, 0);
    check("reset_busy", busy, 0);

    // Basic and signed corners
    op(0, 4'd3, 4'd5, 8'h0F, 0);
    check("basic_z1_idle", z1, 8'h00);
    op(1, 4'h8, 4'h8, 8'h40, 0);
    op(1, 4'h8, 4'h7, 8'hC8, 0);
    op(1, 4'h7, 4'h8, 8'hC8, 0);
    op(1, 4'hF, 4'hF, 8'h01, 0);

    // Operands and req disturbed after capture
    op(0, 4'd2, 4'd3, 8'h06, 1);

    // Contention from reset: port 0 first, then alternating
    do_reset();
    exp_q.push_back({1'b0, 8'hF1});
    exp_q.push_back({1'b1, 8'hD6});
    exp_q.push_back({1'b0, 8'hF1});
    exp_q.push_back({1'b1, 8'hD6});
    drive(0, 1'b1, 4'hD, 4'h5);
    drive(1, 1'b1, 4'h6, 4'h9);
    acks = 0;
    cyc  = 0;
    while (acks < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        ack_cyc[acks]  = cyc;
        ack_port[acks] = int'(ack1);
        acks++;
      end
    end
    req0 = 0;
    req1 = 0;
    check("contention_acks", acks, 4);
    for (int i = 0; i < acks; i++) begin
      check("contention_port", ack_port[i], i % 2);
      if (i > 0) check("contention_spacing", ack_cyc[i] - ack_cyc[i-1], W + 2);
      $display("grant %0d port=%0d cycle=%0d", i, ack_port[i], ack_cyc[i]);
    end
    repeat (W + 3) @(negedge clk);
    check("contention_drained", exp_q.size(), 0);

    // Reset in the middle of RUN: nothing queued, so any done is flagged
    drive(1, 1'b1, 4'd3, 4'd3);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack1 && cyc < 20);
    check("midrun_ack", int'(ack1), 1);
    drive(1, 1'b0, 4'd3, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    check("midrun_z0", z0, 0);
    check("midrun_z1", z1, 0);
    check("midrun_busy_after", busy, 0);
    op(1, 4'hB, 4'hA, 8'h1E, 0);

    // Exhaustive, alternating ports
    for (int i = 0; i < 256; i++) begin
      sx = W'(i >> W);
      sy = W'(i);
      sp = 2*W'(sx) * 2*W'(sy);
      sp = (2*W)'($signed({{W{sx[W-1]}}, sx}) * $signed({{W{sy[W-1]}}, sy}));
      op(i[0], sx, sy, sp, 0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
